// File: rtl/mem_ctrl_if.sv
// Word-wide request port between the MEM pipeline stage and mem_ctrl.
//
// Handshake: the master holds mem_ce_i high with a stable request; the
// slave samples it only while idle. Completion is a single-cycle
// mem_ready_o pulse with mem_data_o valid in that same cycle. stall_o is
// mem_ce_i & ~mem_ready_o and freezes the pipeline until that pulse. The
// master may present the next request from the cycle after the pulse.
interface mem_ctrl_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        stall_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, mem_ready_o, stall_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, mem_ready_o, stall_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises one word request into byte accesses on an 8-bit synchronous
// RAM (one-cycle read latency) and returns the assembled word with a
// one-cycle ready pulse. Lane k lives at byte address base+k and in word
// bits [31-8k:24-8k]; select bit 3-k enables lane k.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_ctrl_if.slave             bus,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_data_o,
    input  logic [7:0]            ram_data_i,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-3:0] r_base_word;   // word base, low two bits implied 0
    logic [3:0]            r_sel_left;    // lanes still to be presented
    logic [1:0]            r_cur_lane;    // lane presented this cycle
    logic                  r_we;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rbuf;
    logic [31:0]           r_data_o;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_we;
    logic [7:0]            r_ram_data;
    // A load lane presented last cycle returns its byte on ram_data_i now.
    logic                  r_cap_valid;
    logic [1:0]            r_cap_lane;

    logic [31:0]           w_rbuf_next;
    logic [1:0]            w_new_lane;
    logic [1:0]            w_next_lane;
    logic                  w_unused;

    // Lowest-numbered enabled lane (lane 0 = sel bit 3).
    function automatic logic [1:0] first_lane(input logic [3:0] sel);
        if (sel[3])      return 2'd0;
        else if (sel[2]) return 2'd1;
        else if (sel[1]) return 2'd2;
        else             return 2'd3;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b1000 >> lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
        case (lane)
            2'd0:    return data[31:24];
            2'd1:    return data[23:16];
            2'd2:    return data[15:8];
            default: return data[7:0];
        endcase
    endfunction

    assign w_new_lane  = first_lane(bus.mem_sel_i);
    assign w_next_lane = first_lane(r_sel_left);
    // Address bits above the RAM and the byte offset are deliberately dropped.
    assign w_unused    = ^bus.mem_addr_i;

    // Merge the returning read byte into its lane of the read buffer.
    always_comb begin
        w_rbuf_next = r_rbuf;
        if (r_cap_valid) begin
            case (r_cap_lane)
                2'd0:    w_rbuf_next[31:24] = ram_data_i;
                2'd1:    w_rbuf_next[23:16] = ram_data_i;
                2'd2:    w_rbuf_next[15:8]  = ram_data_i;
                default: w_rbuf_next[7:0]   = ram_data_i;
            endcase
        end
    end

    // Request FSM: accept in IDLE, present one lane per cycle, drain the
    // final read byte for loads, then pulse ready for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_base_word <= '0;
            r_sel_left  <= '0;
            r_cur_lane  <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_data_o    <= '0;
            r_ready     <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_data  <= '0;
            r_cap_valid <= 1'b0;
            r_cap_lane  <= '0;
        end else begin
            r_cap_valid <= 1'b0;
            r_ready     <= 1'b0;
            r_rbuf      <= w_rbuf_next;
            case (r_state)
                IDLE: begin
                    r_data_o <= '0;
                    if (bus.mem_ce_i) begin
                        r_base_word <= bus.mem_addr_i[ADDR_WIDTH-1:2];
                        r_we        <= bus.mem_we_i;
                        r_wdata     <= bus.mem_data_i;
                        r_rbuf      <= '0;
                        if (bus.mem_sel_i == 4'b0000) begin
                            // Nothing to access: complete on the next cycle.
                            r_sel_left <= '0;
                            r_ready    <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_cur_lane <= w_new_lane;
                            r_sel_left <= bus.mem_sel_i & ~lane_mask(w_new_lane);
                            r_ram_addr <= {bus.mem_addr_i[ADDR_WIDTH-1:2], w_new_lane};
                            r_ram_we   <= bus.mem_we_i;
                            if (bus.mem_we_i) begin
                                r_ram_data <= lane_byte(bus.mem_data_i, w_new_lane);
                            end
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_cap_valid <= ~r_we;
                    r_cap_lane  <= r_cur_lane;
                    if (r_sel_left != 4'b0000) begin
                        r_cur_lane <= w_next_lane;
                        r_sel_left <= r_sel_left & ~lane_mask(w_next_lane);
                        r_ram_addr <= {r_base_word, w_next_lane};
                        if (r_we) begin
                            r_ram_data <= lane_byte(r_wdata, w_next_lane);
                        end
                    end else begin
                        r_ram_we <= 1'b0;
                        if (r_we) begin
                            r_ready <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last load byte arrives now; publish the complete word.
                    r_data_o <= w_rbuf_next;
                    r_ready  <= 1'b1;
                    r_state  <= DONE;
                end
                default: begin
                    r_data_o <= '0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_data_o  = r_data_o;
    assign bus.mem_ready_o = r_ready;
    assign bus.stall_o     = bus.mem_ce_i & ~r_ready;
    assign ram_addr_o      = r_ram_addr;
    assign ram_we_o        = r_ram_we;
    assign ram_data_o      = r_ram_data;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model with one-cycle read latency, a shadow
// memory that predicts load words and store byte writes, and per-scenario
// tasks checking latency, stall behaviour and presented addresses.
module tb_mem_ctrl;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ram_addr_o;
    logic          ram_we_o;
    logic [7:0]    ram_data_o;
    logic [7:0]    ram_data_i = 8'h00;
    logic [1:0]    dbg_state_o;

    mem_ctrl_if bus();

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .ram_addr_o (ram_addr_o),
        .ram_we_o   (ram_we_o),
        .ram_data_o (ram_data_o),
        .ram_data_i (ram_data_i),
        .dbg_state_o(dbg_state_o)
    );

    logic [7:0]    ram_mem [0:(1<<AW)-1];
    logic [7:0]    shadow  [0:(1<<AW)-1];
    logic [31:0]   exp_q[$];
    logic [AW+7:0] exp_wr_q[$];
    logic [AW-1:0] addr_log[$];
    int            n_cmp = 0;
    int            n_fail = 0;

    // Clock
    always #5 clk = ~clk;

    // Synchronous byte RAM, read-before-write, one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we_o) ram_mem[ram_addr_o] <= ram_data_o;
        ram_data_i <= ram_mem[ram_addr_o];
    end

    // Scoreboard: pop expected store bytes and completion words as they appear.
    always @(negedge clk) begin
        logic [AW+7:0] w;
        logic [31:0]   d;
        if (!rst && ram_we_o) begin
            n_cmp++;
            if (exp_wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL ram_write: got addr=%h data=%h, required no write", ram_addr_o, ram_data_o);
            end else begin
                w = exp_wr_q.pop_front();
                if ({ram_addr_o, ram_data_o} !== w)  begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             ram_addr_o, ram_data_o, w[AW+7:8], w[7:0]);
                end
            end
        end
        if (!rst && bus.mem_ready_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ready_data: got unexpected ready with data=%h", bus.mem_data_o);
            end else begin
                d = exp_q.pop_front();
                if (bus.mem_data_o !== d) begin
                    n_fail++;
                    $display("FAIL ready_data: got %h, required %h", bus.mem_data_o, d);
                end
            end
        end
    end

    // Predict a request: store bytes, completion word and ready latency.
    task automatic expect_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                              input logic [31:0] data, output int lat);
        int          base;
        int          n;
        logic [31:0] word;
        base = int'(addr & 32'h0001_FFFC);
        n    = 0;
        word = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel[3-k]) begin
                n++;
                if (we) begin
                    exp_wr_q.push_back({AW'(base + k), data[31-8*k -: 8]});
                    shadow[base + k] = data[31-8*k -: 8];
                end else begin
                    word[31-8*k -: 8] = shadow[base + k];
                end
            end
        end
        exp_q.push_back(word);
        lat = (n == 0) ? 1 : (we ? n + 1 : n + 2);
    endtask

    // Drive one request, observe stall/ready per cycle, log presented addresses.
    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                             input logic [31:0] data, input int exp_lat, input bit disturb,
                             output int lat, output int stall_bad, output logic [31:0] rdata);
        lat       = -1;
        stall_bad = 0;
        rdata     = '0;
        addr_log.delete();
        @(negedge clk);
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = we;
        bus.mem_addr_i = addr;
        bus.mem_sel_i  = sel;
        bus.mem_data_i = data;
        #1;
        if (bus.stall_o !== 1'b1) stall_bad++;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (disturb && c <= 3) begin
                bus.mem_ce_i   = (c % 2 == 0);
                bus.mem_we_i   = 1'($urandom_range(0, 1));
                bus.mem_addr_i = $urandom;
                bus.mem_sel_i  = 4'($urandom_range(0, 15));
                bus.mem_data_i = $urandom;
            end else if (disturb && c == 4) begin
                bus.mem_ce_i = 1'b1;
            end
            #1;
            if (bus.stall_o !== (bus.mem_ce_i && (c != exp_lat))) stall_bad++;
            if (bus.mem_ready_o === 1'b1) begin
                lat   = c;
                rdata = bus.mem_data_o;
                break;
            end
            addr_log.push_back(ram_addr_o);
        end
        @(posedge clk);
        #1;
        bus.mem_ce_i = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({bus.mem_data_o, bus.mem_ready_o, ram_addr_o, ram_we_o, ram_data_o, dbg_state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h rdy=%b addr=%h we=%b wd=%h st=%0d, required all 0",
                     bus.mem_data_o, bus.mem_ready_o, ram_addr_o, ram_we_o, ram_data_o, dbg_state_o);
        end
        bus.mem_ce_i = 1'b1;
        #1;
        n_cmp++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_stall: got %b, required 1", bus.stall_o);
        end
        bus.mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        // Store interrupted by reset during c2; only the c1 byte is written.
        exp_wr_q.push_back({AW'(32'h100), 8'h11});
        @(negedge clk);
        bus.mem_ce_i   = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_addr_i = 32'h100;
        bus.mem_sel_i  = 4'hF;
        bus.mem_data_i = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_cmp++;
        if (ram_we_o !== 1'b1 || ram_addr_o !== AW'(32'h101) || ram_data_o !== 8'h22) begin
            n_fail++;
            $display("FAIL reset_pre_c2: got we=%b addr=%h data=%h, required we=1 addr=101 data=22",
                     ram_we_o, ram_addr_o, ram_data_o);
        end
        bus.mem_ce_i = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ram_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_we: got %b, required 0", ram_we_o);
        end
        n_cmp++;
        if ({bus.mem_data_o, bus.mem_ready_o, ram_addr_o, ram_data_o, dbg_state_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got data=%h rdy=%b addr=%h wd=%h st=%0d, required all 0",
                     bus.mem_data_o, bus.mem_ready_o, ram_addr_o, ram_data_o, dbg_state_o);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_writes: got %0d expected writes missing, required 0", exp_wr_q.size());
            exp_wr_q.delete();
        end
        rst = 1'b0;
    endtask

    task automatic test_sw();
        int el, lat, sb;
        logic [31:0] rd;
        expect_req(1'b1, 32'h100, 4'hF, 32'h11223344, el);
        drive_req(1'b1, 32'h100, 4'hF, 32'h11223344, el, 1'b0, lat, sb, rd);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL sw_latency: got %0d, required 5", lat); end
        n_cmp++;
        if (sb !== 0) begin n_fail++; $display("FAIL sw_stall: got %0d bad cycles, required 0", sb); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (addr_log.size() <= k || addr_log[k] !== AW'(32'h100 + k)) begin
                n_fail++;
                $display("FAIL sw_addr: lane %0d got %h, required %h", k,
                         (addr_log.size() > k) ? addr_log[k] : '1, AW'(32'h100 + k));
            end
        end
    endtask

    task automatic test_lw(input bit disturb);
        int el, lat, sb;
        logic [31:0] rd;
        expect_req(1'b0, 32'h100, 4'hF, 32'h0, el);
        drive_req(1'b0, 32'h100, 4'hF, 32'h0, el, disturb, lat, sb, rd);
        n_cmp++;
        if (lat !== 6) begin n_fail++; $display("FAIL lw_latency: got %0d, required 6 (disturb=%0d)", lat, disturb); end
        n_cmp++;
        if (rd !== 32'h11223344) begin n_fail++; $display("FAIL lw_data: got %h, required 11223344", rd); end
        n_cmp++;
        if (sb !== 0) begin n_fail++; $display("FAIL lw_stall: got %0d bad cycles, required 0", sb); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (addr_log.size() <= k || addr_log[k] !== AW'(32'h100 + k)) begin
                n_fail++;
                $display("FAIL lw_addr: lane %0d got %h, required %h", k,
                         (addr_log.size() > k) ? addr_log[k] : '1, AW'(32'h100 + k));
            end
        end
    endtask

    task automatic test_lb();
        int el, lat, sb;
        logic [31:0] rd;
        expect_req(1'b0, 32'h102, 4'b0010, 32'h0, el);
        drive_req(1'b0, 32'h102, 4'b0010, 32'h0, el, 1'b0, lat, sb, rd);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d, required 3", lat); end
        n_cmp++;
        if (rd !== 32'h00003300) begin n_fail++; $display("FAIL lb_data: got %h, required 00003300", rd); end
        n_cmp++;
        if (addr_log.size() == 0 || addr_log[0] !== AW'(32'h102)) begin
            n_fail++;
            $display("FAIL lb_addr: got %h, required 102", (addr_log.size() > 0) ? addr_log[0] : '1);
        end
    endtask

    task automatic test_sh_lh();
        int el, lat, sb;
        logic [31:0] rd;
        expect_req(1'b1, 32'h202, 4'b0011, 32'hAABBCCDD, el);
        drive_req(1'b1, 32'h202, 4'b0011, 32'hAABBCCDD, el, 1'b0, lat, sb, rd);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d, required 3", lat); end
        n_cmp++;
        if (addr_log.size() != 2 || addr_log[0] !== AW'(32'h202) || addr_log[1] !== AW'(32'h203)) begin
            n_fail++;
            $display("FAIL sh_addr: got %0d entries first=%h, required 202,203",
                     addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : '1);
        end
        expect_req(1'b0, 32'h200, 4'b1100, 32'h0, el);
        drive_req(1'b0, 32'h200, 4'b1100, 32'h0, el, 1'b0, lat, sb, rd);
        n_cmp++;
        if (lat !== 4) begin n_fail++; $display("FAIL lh_latency: got %0d, required 4", lat); end
        n_cmp++;
        if (rd !== 32'h5AA50000) begin n_fail++; $display("FAIL lh_data: got %h, required 5aa50000", rd); end
        n_cmp++;
        if (sb !== 0) begin n_fail++; $display("FAIL lh_stall: got %0d bad cycles, required 0", sb); end
    endtask

    task automatic test_sel_zero();
        int el, lat, sb;
        logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            expect_req(1'(i), 32'h300, 4'b0000, 32'hDEADBEEF, el);
            drive_req(1'(i), 32'h300, 4'b0000, 32'hDEADBEEF, el, 1'b0, lat, sb, rd);
            n_cmp++;
            if (lat !== 1 || rd !== 32'h0) begin
                n_fail++;
                $display("FAIL sel0: we=%0d got lat=%0d data=%h, required lat=1 data=0", i, lat, rd);
            end
            n_cmp++;
            if (sb !== 0) begin n_fail++; $display("FAIL sel0_stall: got %0d bad cycles, required 0", sb); end
        end
    endtask

    task automatic test_back_to_back();
        int el, lat, sb;
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            expect_req(1'b1, a, s, d, el);
            drive_req(1'b1, a, s, d, el, 1'b0, lat, sb, rd);
            n_cmp++;
            if (lat !== el || sb !== 0) begin
                n_fail++;
                $display("FAIL b2b_store: sel=%b got lat=%0d stall_bad=%0d, required lat=%0d stall_bad=0", s, lat, sb, el);
            end
            s = (i % 2 == 0) ? 4'hF : 4'($urandom_range(1, 15));
            expect_req(1'b0, a, s, 32'h0, el);
            drive_req(1'b0, a, s, 32'h0, el, 1'b0, lat, sb, rd);
            n_cmp++;
            if (lat !== el || sb !== 0) begin
                n_fail++;
                $display("FAIL b2b_load: sel=%b got lat=%0d stall_bad=%0d, required lat=%0d stall_bad=0", s, lat, sb, el);
            end
        end
    endtask

    initial begin
        bus.mem_ce_i   = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = '0;
        bus.mem_sel_i  = '0;
        bus.mem_data_i = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = 8'h00;
            shadow[i]  = 8'h00;
        end
        ram_mem[32'h200] = 8'h5A; shadow[32'h200] = 8'h5A;
        ram_mem[32'h201] = 8'hA5; shadow[32'h201] = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_sw();
        test_lw(1'b0);
        test_lb();
        test_sh_lh();
        test_lw(1'b1);
        test_sel_zero();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || exp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d words and %0d writes pending, required 0 and 0",
                     exp_q.size(), exp_wr_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
